// File: rtl/hs_ram_sequencer.sv
// rtl/hs_ram_sequencer.sv - high-score save/restore sequencer between the hiscore byte stream and work RAM
module hs_ram_sequencer #(
    parameter  int AW     = 16,
    parameter  int LW     = 8,
    parameter  int NREG   = 4,
    parameter  int SETTLE = 4,
    parameter  int RD_LAT = 1,
    localparam int IW     = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cfg_wr,
    input  logic [IW-1:0] cfg_idx,
    input  logic [AW-1:0] cfg_base,
    input  logic [LW-1:0] cfg_len,
    input  logic          xfer_start,
    input  logic          xfer_dir,
    input  logic          abort,
    input  logic          s_valid,
    input  logic [7:0]    s_data,
    output logic          s_ready,
    output logic          m_valid,
    output logic [7:0]    m_data,
    input  logic          m_ready,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_wdata,
    output logic          ram_we,
    output logic          ram_access,
    input  logic [7:0]    ram_rdata,
    output logic          pause_req,
    output logic          busy,
    output logic          done,
    output logic          aborted
);

    typedef enum logic [3:0] {
        IDLE, PAUSE, SEEK, W_WAIT, W_DO, R_ISSUE, R_WAIT, R_HOLD, RELEASE
    } state_t;

    localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);
    localparam logic [1:0] LAT_M1    = 2'(RD_LAT - 1);

    state_t          state_q, state_d;
    logic [7:0]      settle_q, settle_d;
    logic [1:0]      lat_q, lat_d;
    logic [IW:0]     idx_q, idx_d;      // extra MSB marks "past the last entry"
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic            dir_q, dir_d;
    logic            m_valid_q, m_valid_d;
    logic [7:0]      m_data_q, m_data_d;
    logic            done_q, done_d;
    logic            aborted_q, aborted_d;

    logic [AW-1:0]   base_q [NREG];
    logic [LW-1:0]   len_q  [NREG];
    logic [AW-1:0]   cur_base;
    logic [LW-1:0]   cur_len;

    assign cur_base = base_q[idx_q[IW-1:0]];
    assign cur_len  = len_q[idx_q[IW-1:0]];

    // Region table: only writable while no transfer is running
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                base_q[i] <= '0;
                len_q[i]  <= '0;
            end
        end else if (cfg_wr && state_q == IDLE) begin
            base_q[cfg_idx] <= cfg_base;
            len_q[cfg_idx]  <= cfg_len;
        end
    end

    // Sequencer state and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            settle_q  <= '0;
            lat_q     <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            lat_q     <= lat_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    // Next-state: walk the table in order, one byte per handshake; abort overrides all
    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        lat_d     = lat_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        done_d    = 1'b0;
        aborted_d = aborted_q;
        case (state_q)
            IDLE: begin
                if (xfer_start) begin
                    dir_d     = xfer_dir;
                    aborted_d = 1'b0;
                    settle_d  = SETTLE_M1;
                    state_d   = PAUSE;
                end
            end
            PAUSE: begin
                if (settle_q == 8'd0) begin
                    idx_d   = '0;
                    state_d = SEEK;
                end else begin
                    settle_d = settle_q - 8'd1;
                end
            end
            SEEK: begin
                if (idx_q[IW]) begin
                    state_d = RELEASE;
                end else if (cur_len == '0) begin
                    idx_d = idx_q + (IW + 1)'(1);
                end else begin
                    ptr_d   = cur_base;
                    cnt_d   = cur_len;
                    state_d = dir_q ? R_ISSUE : W_WAIT;
                end
            end
            W_WAIT: begin
                if (s_valid) state_d = W_DO;
            end
            W_DO: begin
                ptr_d = ptr_q + AW'(1);
                cnt_d = cnt_q - LW'(1);
                if (cnt_q == LW'(1)) begin
                    idx_d   = idx_q + (IW + 1)'(1);
                    state_d = SEEK;
                end else begin
                    state_d = W_WAIT;
                end
            end
            R_ISSUE: begin
                lat_d   = LAT_M1;
                state_d = R_WAIT;
            end
            R_WAIT: begin
                if (lat_q == 2'd0) begin
                    m_data_d  = ram_rdata;
                    m_valid_d = 1'b1;
                    state_d   = R_HOLD;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            R_HOLD: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    ptr_d     = ptr_q + AW'(1);
                    cnt_d     = cnt_q - LW'(1);
                    if (cnt_q == LW'(1)) begin
                        idx_d   = idx_q + (IW + 1)'(1);
                        state_d = SEEK;
                    end else begin
                        state_d = R_ISSUE;
                    end
                end
            end
            RELEASE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE && state_q != RELEASE) begin
            state_d   = RELEASE;
            aborted_d = 1'b1;
            m_valid_d = 1'b0;
        end
    end

    // RAM is held only between settle and release, so access drops a cycle before pause
    assign ram_access = (state_q == SEEK) || (state_q == W_WAIT) || (state_q == W_DO) ||
                        (state_q == R_ISSUE) || (state_q == R_WAIT) || (state_q == R_HOLD);
    assign busy       = (state_q != IDLE);
    assign pause_req  = (state_q != IDLE);
    assign s_ready    = (state_q == W_WAIT);
    assign ram_we     = (state_q == W_WAIT) && s_valid && !abort;
    assign ram_wdata  = ram_we ? s_data : 8'h00;
    assign ram_addr   = ptr_q;
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign done       = done_q;
    assign aborted    = aborted_q;

endmodule

// File: doc/hs_ram_sequencer.md
Name: hs_ram_sequencer

Overview:
- Sequences high-score save/restore traffic into the game work RAM.
- Holds a small region table (base, length per entry) and streams bytes between the HPS-side hiscore byte stream and the RAM regions in table order.
- Stalls the CPU through the pause system while it accesses RAM, and takes the RAM port (ram_access) only after a settle delay.
- Sits between the hiscore/ioctl logic and the core's hs_address / hs_data / hs_write / hs_access interface.

Parameters:
- AW, 16, RAM address width.
- LW, 8, region length width; a length of 0 disables the entry.
- NREG, 4, number of region table entries (power of 2).
- SETTLE, 4, cycles between pause_req assertion and first RAM access (range 1..255).
- RD_LAT, 1, RAM read latency in cycles (range 1..3).

Ports:
- clk  in  1  system clock (clk_sys domain).
- reset_n  in  1  asynchronous active-low reset.
- cfg_wr  in  1  write one region table entry; ignored while busy.
- cfg_idx  in  log2(NREG)  entry index.
- cfg_base  in  AW  region start address.
- cfg_len  in  LW  region length in bytes.
- xfer_start  in  1  start-transfer pulse; ignored while busy.
- xfer_dir  in  1  sampled with xfer_start: 0 = restore (stream to RAM), 1 = dump (RAM to stream).
- abort  in  1  terminate the current transfer.
- s_valid  in  1  restore byte valid.
- s_data  in  8  restore byte.
- s_ready  out  1  restore byte accepted.
- m_valid  out  1  dump byte valid.
- m_data  out  8  dump byte.
- m_ready  in  1  dump byte consumed.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  8  RAM write data.
- ram_we  out  1  RAM write strobe, one cycle per byte.
- ram_access  out  1  RAM port muxed to this block.
- ram_rdata  in  8  RAM read data.
- pause_req  out  1  CPU pause request into the pause block.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at end of transfer, normal or aborted.
- aborted  out  1  sticky abort flag; cleared on the next xfer_start.

Behaviour:
- Reset (async, reset_n=0):
  - All outputs 0, state IDLE.
  - Region table cleared to len=0; aborted cleared.
- Region table:
  - Registered; cfg_wr writes the entry at the next clock edge.
  - A write while busy is dropped.
- States: IDLE, PAUSE, SEEK, W_WAIT, W_DO, R_ISSUE, R_WAIT, R_HOLD, RELEASE.
- IDLE:
  - xfer_start latches dir, clears aborted, sets busy=1 and pause_req=1, loads the settle counter, and goes to PAUSE.
- PAUSE:
  - Counts SETTLE cycles, then sets ram_access=1, sets region index to 0, and goes to SEEK.
- SEEK:
  - Skips entries with len=0, one cycle per entry.
  - On a non-empty entry: load ptr=base and cnt=len, then go to W_WAIT (restore) or R_ISSUE (dump).
  - When the index passes NREG-1: go to RELEASE.
  - An all-zero table reaches RELEASE after NREG+1 cycles.
- W_WAIT:
  - s_ready=1.
  - On s_valid: ram_addr=ptr, ram_wdata=s_data, ram_we=1 for exactly that cycle, then W_DO.
- W_DO:
  - ptr+1 with wrap modulo 2^AW; cnt-1.
  - If cnt reaches 0, go to SEEK with the next index; otherwise go to W_WAIT.
  - Throughput is 1 byte per 2 cycles.
- R_ISSUE:
  - Drive ram_addr=ptr, then go to R_WAIT.
- R_WAIT:
  - Wait RD_LAT cycles, capture ram_rdata into m_data, set m_valid=1, go to R_HOLD.
- R_HOLD:
  - m_data stays stable while m_valid=1.
  - On m_ready: m_valid=0, ptr+1, cnt-1, then go to R_ISSUE, or to SEEK when the region is exhausted.
- RELEASE:
  - ram_access=0 in this cycle.
  - Next cycle: pause_req=0, busy=0, done=1 for one cycle, state IDLE.
  - ram_access always drops at least 1 cycle before pause_req.
- abort:
  - From any state except IDLE and RELEASE, go to RELEASE on the next edge and set aborted=1.
  - A pending ram_we is not issued; m_valid is cleared.
  - abort in IDLE is ignored.
- Simultaneous events:
  - xfer_start together with cfg_wr in IDLE: the cfg write takes effect, and the transfer uses the new table because SEEK begins at least SETTLE cycles later.
  - abort together with s_valid in W_WAIT: abort wins, no write, s_ready is still 1 that cycle, and the byte is treated as not consumed.
- Region arithmetic:
  - ptr is AW bits and wraps from 0xFFFF to 0x0000 within a region.
  - len is 1..2^LW-1.
- ram_addr holds its last value when ram_access=0; ram_we is 0 outside W_WAIT handshakes.

Test Plan:
- Reset check: reset_n=0 mid-dump (ram_access=1) -> same cycle all outputs 0, pause_req=0; after release, state IDLE and table cleared.
- Restore: table {0:(0x6000,3)}, stream 0xA1,0xA2,0xA3 -> writes to 0x6000..0x6002 with those bytes; ram_access rises SETTLE cycles after start; done pulses once; ram_access falls 1 cycle before pause_req.
- Dump with skips: table {1:(0x6100,2), 3:(0x61F0,1)}, entries 0 and 2 len=0, RAM holds 0x11,0x22 at 0x6100 and 0x33 at 0x61F0 -> m_data sequence 0x11,0x22,0x33; m_ready held low 5 cycles keeps m_data stable.
- Wrap: entry (0xFFFF,2), restore 0x55,0x66 -> writes to 0xFFFF then 0x0000.
- Empty table: xfer_start with all len=0 -> no ram_we; done arrives SETTLE+NREG+3 cycles after start.
- Abort: abort after first restored byte of len=4 -> exactly 1 ram_we, aborted=1, done pulses once; next xfer_start clears aborted.
